// File: rtl/mem_ctrl.sv
// Memory-stage controller for an asynchronous 16-bit SRAM: 3-cycle access, freezes the pipeline through hold.
// Optional macro MEM_WAIT_STATE_EN inserts one WAIT cycle (4-cycle latency, 2-cycle write pulse).
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] addr,
    input  logic [15:0] write_value,
    output logic [15:0] read_value,
    output logic        done,
    output logic        hold,
    output logic [17:0] ram_addr,
    inout  wire  [15:0] ram_data,
    output logic        ram_en_n,
    output logic        ram_oe_n,
    output logic        ram_we_n
);

`ifdef MEM_WAIT_STATE_EN
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_WAIT, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;
`endif

    state_t      r_state;
    logic        r_is_write;
    logic        r_drive;
    logic        r_en_n;
    logic        r_oe_n;
    logic        r_we_n;
    logic        r_done;
    logic [15:0] r_wdata;
    logic [15:0] r_read_value;
    logic [17:0] r_addr;

    logic        w_req;
    logic        w_busy;
    logic        w_last_access;

    assign w_req = mem_read | mem_write;

    // w_last_access marks the final strobe cycle: read data is sampled at its end
`ifdef MEM_WAIT_STATE_EN
    assign w_busy        = (r_state == S_SETUP) || (r_state == S_ACCESS) || (r_state == S_WAIT);
    assign w_last_access = (r_state == S_WAIT);
`else
    assign w_busy        = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign w_last_access = (r_state == S_ACCESS);
`endif

    assign hold = ((r_state == S_IDLE) && w_req) || w_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_is_write   <= 1'b0;
            r_drive      <= 1'b0;
            r_en_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_we_n       <= 1'b1;
            r_done       <= 1'b0;
            r_wdata      <= 16'h0000;
            r_read_value <= 16'h0000;
            r_addr       <= 18'h00000;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        // a simultaneous read+write request is treated as a write
                        r_state    <= S_SETUP;
                        r_is_write <= mem_write;
                        r_wdata    <= write_value;
                        r_addr     <= {2'b00, addr};
                        r_en_n     <= 1'b0;
                        r_oe_n     <= mem_write;
                        r_we_n     <= 1'b1;
                        r_drive    <= mem_write;
                    end
                end
                S_SETUP: begin
                    r_state <= S_ACCESS;
                    r_we_n  <= ~r_is_write;
                end
`ifdef MEM_WAIT_STATE_EN
                S_ACCESS: r_state <= S_WAIT;
                S_WAIT:   r_state <= S_DONE;
`else
                S_ACCESS: r_state <= S_DONE;
`endif
                S_DONE: begin
                    // store data was held through DONE; release bus and chip on return to IDLE
                    r_state <= S_IDLE;
                    r_en_n  <= 1'b1;
                    r_drive <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_last_access) begin
                r_we_n <= 1'b1;
                r_oe_n <= 1'b1;
                r_done <= 1'b1;
                if (!r_is_write) begin
                    r_read_value <= ram_data;
                end
            end
        end
    end

    assign ram_data   = r_drive ? r_wdata : 16'hzzzz;
    assign ram_addr   = r_addr;
    assign ram_en_n   = r_en_n;
    assign ram_oe_n   = r_oe_n;
    assign ram_we_n   = r_we_n;
    assign read_value = r_read_value;
    assign done       = r_done;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: transaction-level model (access start cycle + offset) with a bus-level SRAM.
module tb_mem_ctrl;

`ifdef MEM_WAIT_STATE_EN
    localparam int L = 4;
`else
    localparam int L = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] addr;
    logic [15:0] write_value;
    logic [15:0] read_value;
    logic        done;
    logic        hold;
    logic [17:0] ram_addr;
    wire  [15:0] ram_data;
    logic        ram_en_n;
    logic        ram_oe_n;
    logic        ram_we_n;

    logic        tb_en  = 1'b1;
    logic [15:0] tb_val = 16'h0000;
    assign ram_data = tb_en ? tb_val : 16'hzzzz;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .write_value(write_value), .read_value(read_value),
        .done(done), .hold(hold), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_en_n(ram_en_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    logic [15:0] sram_mem [logic [15:0]];
    logic [15:0] ref_mem  [logic [15:0]];

    function automatic logic [15:0] sram_read(input logic [15:0] a);
        if (sram_mem.exists(a)) return sram_mem[a];
        return a ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return a ^ 16'hA5C3;
    endfunction

    // Model: an access starting in idle cycle t0 occupies cycles t0+1..t0+L, DONE at t0+L
    bit          model_valid = 0;
    bit          active = 0;
    int          cyc = 0;
    int          t0 = 0;
    bit          m_wr = 0;
    logic [15:0] m_addr = 16'h0;
    logic [15:0] m_data = 16'h0;
    logic [15:0] exp_rv = 16'h0;
    bit          exp_drive = 0;

    always begin : model
        int k;
        @(posedge clk);
        if (!ram_en_n && !ram_we_n) sram_mem[ram_addr[15:0]] = ram_data;
        if (active) begin
            k = cyc - t0;
            if (m_wr && k >= 2 && k < L) ref_mem[m_addr] = m_data;
        end
        if (rst) begin
            active      = 0;
            exp_rv      = 16'h0;
            model_valid = 1;
        end else if (model_valid) begin
            if (active) begin
                k = cyc - t0;
                if (!m_wr && k == L - 1) exp_rv = ref_read(m_addr);
                if (k == L) active = 0;
            end else if (mem_read || mem_write) begin
                active = 1;
                t0     = cyc;
                m_wr   = mem_write;
                m_addr = addr;
                m_data = write_value;
            end
        end
        cyc++;
        #1;
        exp_drive = active && m_wr;
        if (!ram_en_n && !ram_oe_n && ram_we_n) begin
            tb_en  = 1'b1;
            tb_val = sram_read(ram_addr[15:0]);
        end else if (!exp_drive) begin
            tb_en  = 1'b1;
            tb_val = 16'($urandom);
        end else begin
            tb_en  = 1'b0;
            tb_val = 16'h0000;
        end
    end

    always @(negedge clk) begin : compare
        int   k;
        logic e_hold, e_done, e_oe, e_we;
        if (model_valid) begin
            k      = active ? (cyc - t0) : 0;
            e_hold = active ? (k < L) : (mem_read | mem_write);
            e_done = active && (k == L);
            e_oe   = !(active && !m_wr && k < L);
            e_we   = !(active && m_wr && k >= 2 && k < L);
            chk("hold", 32'(hold), 32'(e_hold));
            chk("done", 32'(done), 32'(e_done));
            chk("ram_en_n", 32'(ram_en_n), 32'(!active));
            chk("ram_oe_n", 32'(ram_oe_n), 32'(e_oe));
            chk("ram_we_n", 32'(ram_we_n), 32'(e_we));
            chk("read_value", 32'(read_value), 32'(exp_rv));
            if (active) chk("ram_addr", 32'(ram_addr), 32'({2'b00, m_addr}));
            if (exp_drive) chk("bus_store", 32'(ram_data), 32'(m_data));
            else           chk("bus_release", 32'(ram_data), 32'(tb_val));
        end
    end

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        mem_read    = rd;
        mem_write   = wr;
        addr        = a;
        write_value = d;
    endtask

    initial begin
        rst = 1'b1;
        req(1'b0, 1'b0, 16'h0, 16'h0);
        adv(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_en_n", 32'(ram_en_n), 32'h1);
        chk("rst_oe_n", 32'(ram_oe_n), 32'h1);
        chk("rst_we_n", 32'(ram_we_n), 32'h1);
        chk("rst_addr", 32'(ram_addr), 32'h0);
        chk("rst_rv", 32'(read_value), 32'h0);
        chk("rst_hold", 32'(hold), 32'h0);
        chk("rst_done", 32'(done), 32'h0);

        // store 0xBEEF at 0x1234
        adv(1); req(1'b0, 1'b1, 16'h1234, 16'hBEEF);
        @(negedge clk); chk("st_hold_T", 32'(hold), 32'h1);
        adv(1); req(1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        chk("st_addr_T1", 32'(ram_addr), 32'h01234);
        chk("st_bus_T1", 32'(ram_data), 32'hBEEF);
        chk("st_we_T1", 32'(ram_we_n), 32'h1);
        adv(1);
        @(negedge clk); chk("st_we_T2", 32'(ram_we_n), 32'h0);
        adv(L - 2);
        @(negedge clk);
        chk("st_done", 32'(done), 32'h1);
        chk("st_hold_done", 32'(hold), 32'h0);
        chk("st_bus_done", 32'(ram_data), 32'hBEEF);

        // load it back
        adv(1); req(1'b1, 1'b0, 16'h1234, 16'h0);
        adv(1); req(1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk); chk("ld_oe_T1", 32'(ram_oe_n), 32'h0);
        adv(L - 1);
        @(negedge clk);
        chk("ld_done", 32'(done), 32'h1);
        chk("ld_rv", 32'(read_value), 32'hBEEF);

        // read+write together acts as a write
        adv(1); req(1'b1, 1'b1, 16'h0042, 16'h00FF);
        adv(1); req(1'b0, 1'b0, 16'h0, 16'h0);
        adv(L - 1);
        @(negedge clk);
        chk("rw_done", 32'(done), 32'h1);
        chk("rw_rv_kept", 32'(read_value), 32'hBEEF);
        adv(1); req(1'b1, 1'b0, 16'h0042, 16'h0);
        adv(1); req(1'b0, 1'b0, 16'h0, 16'h0);
        adv(L - 1);
        @(negedge clk); chk("rw_readback", 32'(read_value), 32'h00FF);

        // back-to-back loads held on the inputs
        adv(1); req(1'b1, 1'b0, 16'h1234, 16'h0);
        adv(L);
        @(negedge clk); chk("b2b_done1", 32'(done), 32'h1);
        adv(1);
        @(negedge clk); chk("b2b_accept", 32'(hold), 32'h1);
        adv(L);
        req(1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        chk("b2b_done2", 32'(done), 32'h1);
        chk("b2b_rv", 32'(read_value), 32'hBEEF);

        // reset during the strobe cycle of a store
        adv(1); req(1'b0, 1'b1, 16'h0077, 16'h1357);
        adv(1); req(1'b0, 1'b0, 16'h0, 16'h0);
        adv(1); rst = 1'b1;
        adv(1); rst = 1'b0;
        @(negedge clk);
        chk("abort_we", 32'(ram_we_n), 32'h1);
        chk("abort_en", 32'(ram_en_n), 32'h1);
        chk("abort_hold", 32'(hold), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_bus", 32'(ram_data), 32'(tb_val));

        for (int i = 0; i < 600; i++) begin
            adv(1);
            rst         = ($urandom_range(0, 79) == 0);
            mem_read    = ($urandom_range(0, 2) == 0);
            mem_write   = ($urandom_range(0, 2) == 0);
            addr        = 16'($urandom_range(0, 15));
            write_value = 16'($urandom);
        end
        adv(1);
        rst = 1'b0;
        req(1'b0, 1'b0, 16'h0, 16'h0);
        adv(L + 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory-stage SRAM controller for the 16-bit pipeline: it accepts the load/store request produced downstream of the ID/EXE register (mem_read / mem_write, ALU-computed address, store data) and runs the external asynchronous SRAM through a multi-cycle access. While an access is in flight it asserts `hold` back to the pipeline registers, including ID/EXE, so the pipeline freezes. It returns load data and a completion pulse.

## Interface
Parameters:
- none (address/data widths follow `RegValue` = 16 bits; SRAM address is 18 bits)

Ports:
- `clk`  in  1  system clock; all state changes on posedge
- `rst`  in  1  reset; synchronous and active-high
- `mem_read`  in  1  load request from the EX/MEM stage
- `mem_write`  in  1  store request from the EX/MEM stage
- `addr`  in  16  word address (ALU result)
- `write_value`  in  16  store data
- `read_value`  out  16  load result; registered; held until the next load completes
- `done`  out  1  one-cycle pulse in the cycle the access completes
- `hold`  out  1  stall request to the pipeline registers; combinational
- `ram_addr`  out  18  SRAM address, `{2'b00, addr}`; registered
- `ram_data`  inout  16  SRAM data bus; driven only during stores, otherwise `Z`
- `ram_en_n`  out  1  SRAM chip enable, active-low; registered
- `ram_oe_n`  out  1  SRAM output enable, active-low; registered
- `ram_we_n`  out  1  SRAM write enable, active-low; registered

## Operation
States: IDLE, SETUP, ACCESS, [WAIT], DONE. WAIT exists only with the macro described under Configuration.

- **IDLE.** Request = `mem_read | mem_write`.
  - If a request is present, latch addr/write_value/op into internal registers and go to SETUP.
  - If both inputs are asserted, the access is a write and the read is dropped.
  - With no request, stay in IDLE.
- **SETUP.**
  - `ram_addr` = latched address and `ram_en_n`=0.
  - Read: `ram_oe_n`=0, bus Z.
  - Write: `ram_we_n`=1 and the bus drives the latched data.
- **ACCESS.**
  - Read: `ram_oe_n` stays 0; sample `ram_data` into `read_value` at the end of this state (or at the end of WAIT when enabled).
  - Write: `ram_we_n`=0.
- **WAIT.** Repeats the ACCESS signal levels for one more cycle.
- **DONE.**
  - `done`=1, `ram_we_n`=1 and `ram_oe_n`=1.
  - For a write, the bus remains driven this cycle (data hold time) and is released on entry to IDLE.
  - Always returns to IDLE. No request is accepted in DONE.
- **`hold`** = (IDLE && request) || state ∈ {SETUP, ACCESS, WAIT}. It is low in DONE, so the pipeline advances at the end of DONE.
- **Request inputs** are ignored outside IDLE; the latched copies are used.
- A store leaves `read_value` unchanged.

## Timing
- **Reset values** (on `rst`=1 at posedge, from any state): state IDLE; `ram_en_n`=`ram_oe_n`=`ram_we_n`=1; `ram_addr`=0; `ram_data`=Z; `read_value`=0; `done`=0.
- **Reset mid-access** aborts immediately. A store interrupted after ACCESS may be partially written; this is accepted behaviour.
- **Cycle accounting.** Let T be the IDLE cycle in which a request is seen.
  - `hold`=1 in T, T+1 (SETUP) and T+2 (ACCESS).
  - DONE falls in T+3, where `done`=1, `hold`=0 and `read_value` is valid.
  - Access latency is therefore 3 cycles, 4 with WAIT.
- **Back-to-back requests** always see one IDLE cycle between accesses, in which the new request is evaluated. Throughput is one access per 4 cycles (5 with WAIT).
- **`ram_we_n` low pulse** is exactly 1 cycle (2 with WAIT).
- **Setup guarantee.** Address and data are stable one full cycle before `ram_we_n` falls and remain stable one cycle after it rises.

## Configuration
- **`MEM_WAIT_STATE_EN`** defined: the WAIT state is inserted between ACCESS and DONE.
  - Read sampling moves to the end of WAIT.
  - The write pulse is 2 cycles.
  - Latency is 4 cycles and `hold` is 4 cycles.
- **Undefined:** WAIT is never entered and the state encoding omits it.

## Test plan
- **Reset:** assert `rst` for 2 cycles -> all SRAM controls 1, `ram_data`=Z, `read_value`=0000, `hold`=0, `done`=0.
- **Store:** `mem_write`=1, addr=0x1234, write_value=0xBEEF.
  - `ram_addr`=0x01234 and bus drives 0xBEEF from T+1 to T+3.
  - `ram_we_n`=0 only in T+2.
  - `hold`=1 in T..T+2, `done`=1 in T+3.
- **Load:** the SRAM model returns 0xBEEF at 0x01234; issue `mem_read` at addr=0x1234.
  - `ram_oe_n`=0 in T+1..T+2.
  - `read_value`=0xBEEF with `done`=1 in T+3.
  - The bus is never driven by the controller.
- **Simultaneous request:** `mem_read`=`mem_write`=1 with write_value=0x00FF -> a write is performed and `read_value` is unchanged.
- **Back-to-back:** two loads held on the inputs -> the second access is accepted in T+4 and its `done` appears in T+7.
- **Reset mid-access:** `rst` in T+2 of a store -> next cycle state IDLE, `ram_we_n`=1, bus Z, `hold`=0. Repeat every scenario with `MEM_WAIT_STATE_EN` defined, expecting +1 cycle latency.
